// File: rtl/crc7_h45_pkg.sv
// crc7_h45_pkg: shared CRC7 (x^7+x^3+1) constants and checker FSM encoding.
package crc7_h45_pkg;
    localparam int CRC_W = 7;
    localparam logic [CRC_W-1:0] CRC_POLY = 7'h09;
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, CRC = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/crc7_h45_serial_lfsr.sv
// crc7_h45_serial_lfsr: bit-serial CRC7 LFSR, MSB first, init 0, shared by generator and checker.
module crc7_h45_serial_lfsr
    import crc7_h45_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             in,
    output logic [CRC_W-1:0] crc
);
    always_ff @(posedge clk)
        if (rst || clear) crc <= '0;
        else if (enable) crc <= {crc[CRC_W-2:0], 1'b0} ^ ((in ^ crc[CRC_W-1]) ? CRC_POLY : '0);
endmodule

// File: rtl/crc7_h45_serial_checker.sv
// crc7_h45_serial_checker: checks a serial payload+CRC7 frame against the locally computed CRC.
// Optional saturating error counter port err_cnt when CRC7_CHK_ERR_CNT_EN is defined.
module crc7_h45_serial_checker
    import crc7_h45_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] data_len,
    input  logic             in_valid,
    input  logic             in,
    output logic             busy,
    output logic             done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic [CRC_W-1:0] crc_calc,
    output logic [CRC_W-1:0] crc_rx
`ifdef CRC7_CHK_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);
    localparam logic [LEN_W-1:0] CRC_LEN = LEN_W'(CRC_W);

    state_t state, next_state;
    logic [LEN_W-1:0] cnt;
    logic last, len_zero;
    logic [CRC_W-1:0] rx_next;

    assign last     = cnt == LEN_W'(1);
    assign len_zero = data_len == '0;
    assign rx_next  = {crc_rx[CRC_W-2:0], in};

    crc7_h45_serial_lfsr u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .clear  (start),
        .enable (in_valid && !start && state == DATA),
        .in     (in),
        .crc    (crc_calc)
    );

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= next_state;

    always_comb
        next_state = start ? (len_zero ? CRC : DATA)
                   : state == DATA ? (in_valid && last ? CRC : DATA)
                   : state == CRC  ? (in_valid && last ? DONE : CRC)
                   : IDLE;

    always_comb begin
        busy = state == DATA || state == CRC;
        done = state == DONE;
    end

    // The counter walks the payload, then is reloaded with 7 for the CRC field.
    always_ff @(posedge clk)
        if (rst) begin
            cnt     <= '0;
            crc_rx  <= '0;
            crc_ok  <= 1'b0;
            crc_err <= 1'b0;
        end else if (start) begin
            cnt     <= len_zero ? CRC_LEN : data_len;
            crc_rx  <= '0;
            crc_ok  <= 1'b0;
            crc_err <= 1'b0;
        end else if (in_valid && state == DATA) begin
            cnt <= last ? CRC_LEN : cnt - LEN_W'(1);
        end else if (in_valid && state == CRC) begin
            cnt    <= cnt - LEN_W'(1);
            crc_rx <= rx_next;
            if (last) begin
                crc_ok  <= rx_next == crc_calc;
                crc_err <= rx_next != crc_calc;
            end
        end

`ifdef CRC7_CHK_ERR_CNT_EN
    always_ff @(posedge clk)
        if (rst) err_cnt <= '0;
        else if (done && crc_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_crc7_h45_serial_checker.sv
// tb_crc7_h45_serial_checker: directed and randomized frames checked against a long-division CRC7 model.
module tb_crc7_h45_serial_checker;
    logic clk = 1'b0;
    logic rst, start, in_valid, in_bit;
    logic [7:0] data_len;
    logic busy, done, crc_ok, crc_err;
    logic [6:0] crc_calc, crc_rx;
`ifdef CRC7_CHK_ERR_CNT_EN
    logic [7:0] err_cnt;
    int exp_err = 0;
`endif
    int total = 0, bad = 0, done_seen = 0;

    crc7_h45_serial_checker #(.LEN_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_len (data_len),
        .in_valid (in_valid),
        .in       (in_bit),
        .busy     (busy),
        .done     (done),
        .crc_ok   (crc_ok),
        .crc_err  (crc_err),
        .crc_calc (crc_calc),
        .crc_rx   (crc_rx)
`ifdef CRC7_CHK_ERR_CNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (done === 1'b1) done_seen++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Remainder of payload*x^7 divided by x^7+x^3+1 (0x89), by polynomial long division.
    function automatic logic [6:0] ref_crc(input logic [39:0] p, input int len);
        logic [46:0] r;
        r = 47'(p) << 7;
        for (int b = len + 6; b >= 7; b--)
            if (r[b]) r = r ^ (47'h89 << (b - 7));
        return r[6:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gap: 0 none, 1 alternate valid/idle, 2 random idle cycles; sv drives in_valid=1 during start.
    task automatic send(input int len, input logic [39:0] p, input logic [6:0] c,
                        input int gap, input bit sv, input int nbits);
        start = 1'b1;
        data_len = 8'(len);
        in_valid = sv;
        in_bit = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (gap == 1 && i > 0) begin
                in_valid = 1'b0;
                in_bit = ~in_bit;
                tick();
            end
            if (gap == 2)
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_bit = 1'($urandom);
                    tick();
                end
            in_valid = 1'b1;
            in_bit = i < len ? p[len-1-i] : c[6-(i-len)];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int len, input logic [39:0] p,
                               input logic [6:0] c, input int d0);
        logic [6:0] e;
        e = ref_crc(p, len);
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_calc"}, 32'(crc_calc), 32'(e));
        chk({tag, "_rx"}, 32'(crc_rx), 32'(c));
        chk({tag, "_ok"}, 32'(crc_ok), 32'(c == e));
        chk({tag, "_err"}, 32'(crc_err), 32'(c != e));
        tick();
        chk({tag, "_done_drop"}, 32'(done), 0);
        chk({tag, "_ok_hold"}, 32'(crc_ok), 32'(c == e));
        chk({tag, "_pulses"}, 32'(done_seen - d0), 1);
`ifdef CRC7_CHK_ERR_CNT_EN
        if (c != e && exp_err < 255) exp_err++;
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
`endif
    endtask

    initial begin
        int d0, len;
        logic [39:0] p;
        logic [63:0] r64;
        logic [6:0] c;
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_bit = 1'b1; data_len = 8'd5;
        repeat (3) tick();
        start = 1'b0; in_valid = 1'b0; rst = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ok", 32'(crc_ok), 0);
        chk("rst_err", 32'(crc_err), 0);
        chk("rst_calc", 32'(crc_calc), 0);
        chk("rst_rx", 32'(crc_rx), 0);
`ifdef CRC7_CHK_ERR_CNT_EN
        chk("rst_err_cnt", 32'(err_cnt), 0);
`endif
        tick();

        d0 = done_seen;
        send(40, 40'h4000000000, 7'h4A, 0, 0, 47);
        chk("cmd0_spec_calc", 32'(crc_calc), 32'h4A);
        check_frame("cmd0", 40, 40'h4000000000, 7'h4A, d0);

        d0 = done_seen;
        send(40, 40'h5100000000, 7'h2B, 0, 0, 47);
        chk("cmd17_spec_calc", 32'(crc_calc), 32'h2A);
        check_frame("cmd17_bad", 40, 40'h5100000000, 7'h2B, d0);

        d0 = done_seen;
        send(40, 40'h48000001AA, 7'h43, 1, 0, 47);
        check_frame("cmd8_toggle", 40, 40'h48000001AA, 7'h43, d0);

        d0 = done_seen;
        send(0, 40'h0, 7'h00, 0, 0, 7);
        check_frame("len0", 0, 40'h0, 7'h00, d0);

        d0 = done_seen;
        send(40, 40'h5100000000, 7'h2A, 0, 0, 20);
        chk("abort_busy", 32'(busy), 1);
        send(40, 40'h4000000000, 7'h4A, 0, 0, 47);
        check_frame("abort_restart", 40, 40'h4000000000, 7'h4A, d0);

        d0 = done_seen;
        send(40, 40'h4000000000, 7'h4A, 0, 1, 47);
        check_frame("start_valid", 40, 40'h4000000000, 7'h4A, d0);

        d0 = done_seen;
        send(40, 40'h4000000000, 7'h4A, 0, 0, 43);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_ok", 32'(crc_ok), 0);
        chk("midrst_err", 32'(crc_err), 0);
        chk("midrst_calc", 32'(crc_calc), 0);
        chk("midrst_rx", 32'(crc_rx), 0);
`ifdef CRC7_CHK_ERR_CNT_EN
        exp_err = 0;
        chk("midrst_err_cnt", 32'(err_cnt), 0);
`endif
        in_valid = 1'b1;
        repeat (10) tick();
        in_valid = 1'b0;
        chk("midrst_no_done", 32'(done_seen - d0), 0);
        d0 = done_seen;
        send(40, 40'h48000001AA, 7'h43, 0, 0, 47);
        check_frame("after_rst", 40, 40'h48000001AA, 7'h43, d0);

        for (int k = 0; k < 12; k++) begin
            len = $urandom_range(0, 40);
            r64 = {$urandom, $urandom};
            p = r64[39:0] & ((40'd1 << len) - 40'd1);
            c = ref_crc(p, len);
            if ($urandom_range(0, 1) == 1) c = c ^ (7'd1 << $urandom_range(0, 6));
            d0 = done_seen;
            send(len, p, c, 2, 0, len + 7);
            check_frame("rand", len, p, c, d0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
